// File: rtl/rvi_addsub_pipe_if.sv
// ---------------------------------------------------------------------------
// rvi_addsub_pipe_if
// Operation/result bus of the pipelined add/sub/compare execute unit.
//   in_vld/in_rdy   : issue-side handshake
//   in_op           : [0] add, [1] sub, [2] word form
//   in_unsigned     : unsigned less-than compare
//   in_s1/in_s2     : source operands
//   in_tag          : opaque tag returned with the result
//   out_vld/out_rdy : writeback-side handshake
//   out_rslt/out_lt : result and less-than flag
//   out_tag         : tag of the result
// Handshake: a beat transfers on a rising edge where vld & rdy are both high;
// a producer holding vld high keeps its payload stable until that transfer.
// master = issue/writeback side (testbench), slave = execute unit.
// ---------------------------------------------------------------------------
interface rvi_addsub_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             in_vld;
    logic             in_rdy;
    logic [2:0]       in_op;
    logic             in_unsigned;
    logic [XLEN-1:0]  in_s1;
    logic [XLEN-1:0]  in_s2;
    logic [TAG_W-1:0] in_tag;
    logic             out_vld;
    logic             out_rdy;
    logic [XLEN-1:0]  out_rslt;
    logic             out_lt;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_vld, in_op, in_unsigned, in_s1, in_s2, in_tag, out_rdy,
        input  in_rdy, out_vld, out_rslt, out_lt, out_tag
    );

    modport slave (
        input  in_vld, in_op, in_unsigned, in_s1, in_s2, in_tag, out_rdy,
        output in_rdy, out_vld, out_rslt, out_lt, out_tag
    );
endinterface

// File: rtl/rvi_addsub_pipe.sv
// ---------------------------------------------------------------------------
// rvi_addsub_pipe
// Pipelined integer add/subtract/less-than execute unit. The arithmetic is
// done combinationally in front of stage 0; the result, lt flag and tag are
// then carried through STAGES elastic register stages (latency = STAGES).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   flush : synchronous kill of all in-flight operations
//   bus   : rvi_addsub_pipe_if.slave operation/result bus
// Parameters: XLEN (32 or 64), STAGES (1..4), TAG_W.
// ---------------------------------------------------------------------------
module rvi_addsub_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    rvi_addsub_pipe_if.slave bus
);

    // ---------------- stage 0 arithmetic ----------------
    logic            is_add;
    logic            is_sub;
    logic [XLEN-1:0] s2_eff;
    logic [XLEN-1:0] sum;
    logic [XLEN:0]   ext1;
    logic [XLEN:0]   ext2;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] calc_rslt;
    logic            calc_lt;

    always_comb begin
        is_add = bus.in_op[0];
        is_sub = ~bus.in_op[0] & bus.in_op[1];
        // Subtract as s1 + ~s2 + 1 so one adder serves both operations.
        s2_eff = bus.in_s2 ^ {XLEN{is_sub}};
        sum    = bus.in_s1 + s2_eff + XLEN'(is_sub);

        calc_rslt = '0;
        if (is_add | is_sub) begin
            calc_rslt = sum;
            // Word form: sign-extend bit 31. With XLEN=32 the loop is empty,
            // so op[2] has no effect there.
            if (bus.in_op[2]) begin
                for (int i = 32; i < XLEN; i++) begin
                    calc_rslt[i] = sum[31];
                end
            end
        end

        // One extra bit makes the borrow of the full-width compare visible
        // for both signed and unsigned operands.
        ext1    = {~bus.in_unsigned & bus.in_s1[XLEN-1], bus.in_s1};
        ext2    = {~bus.in_unsigned & bus.in_s2[XLEN-1], bus.in_s2};
        diff    = ext1 - ext2;
        calc_lt = (bus.in_op[1:0] == 2'b10) & diff[XLEN];
    end

    // ---------------- elastic pipeline ----------------
    logic [STAGES-1:0]            vld_q,  vld_d;
    logic [STAGES-1:0][XLEN-1:0]  rslt_q, rslt_d;
    logic [STAGES-1:0]            lt_q,   lt_d;
    logic [STAGES-1:0][TAG_W-1:0] tag_q,  tag_d;

    logic [STAGES-1:0]            rdy;
    logic [STAGES-1:0]            up_vld;
    logic [STAGES-1:0][XLEN-1:0]  up_rslt;
    logic [STAGES-1:0]            up_lt;
    logic [STAGES-1:0][TAG_W-1:0] up_tag;
    logic                         in_rdy_int;

    // rdy_i = ~vld_i | rdy_{i+1}, unrolled as a running OR from the output
    // end so no signal feeds back into its own vector.
    always_comb begin : ready_chain
        logic acc;
        acc = bus.out_rdy;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = acc | ~vld_q[i];
            rdy[i] = acc;
        end
    end

    assign in_rdy_int = rdy[0] & ~flush;

    always_comb begin
        up_vld[0]  = bus.in_vld & in_rdy_int;
        up_rslt[0] = calc_rslt;
        up_lt[0]   = calc_lt;
        up_tag[0]  = bus.in_tag;
        for (int i = 1; i < STAGES; i++) begin
            up_vld[i]  = vld_q[i-1];
            up_rslt[i] = rslt_q[i-1];
            up_lt[i]   = lt_q[i-1];
            up_tag[i]  = tag_q[i-1];
        end
    end

    always_comb begin
        vld_d  = vld_q;
        rslt_d = rslt_q;
        lt_d   = lt_q;
        tag_d  = tag_q;
        for (int i = 0; i < STAGES; i++) begin
            if (flush) begin
                vld_d[i] = 1'b0;
            end else if (rdy[i]) begin
                // A ready stage is empty or being drained this edge, so it
                // takes whatever its upstream offers (possibly nothing).
                vld_d[i] = up_vld[i];
                if (up_vld[i]) begin
                    rslt_d[i] = up_rslt[i];
                    lt_d[i]   = up_lt[i];
                    tag_d[i]  = up_tag[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            rslt_q <= '0;
            lt_q   <= '0;
            tag_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            rslt_q <= rslt_d;
            lt_q   <= lt_d;
            tag_q  <= tag_d;
        end
    end

    assign bus.in_rdy   = in_rdy_int;
    assign bus.out_vld  = vld_q[STAGES-1];
    assign bus.out_rslt = rslt_q[STAGES-1];
    assign bus.out_lt   = lt_q[STAGES-1];
    assign bus.out_tag  = tag_q[STAGES-1];

endmodule

// File: tb/tb_rvi_addsub_pipe.sv
module tb_rvi_addsub_pipe;
    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 6;
    localparam int PW     = XLEN + 1 + TAG_W;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic flush   = 1'b0;
    logic flush32 = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   rx_count = 0;
    logic [PW-1:0] exp_q[$];

    rvi_addsub_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    rvi_addsub_pipe_if #(.XLEN(32),   .TAG_W(TAG_W)) bus32 ();

    rvi_addsub_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    rvi_addsub_pipe #(.XLEN(32), .STAGES(1), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(bus32)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [PW-1:0] model(input logic [2:0] op, input logic uns,
                                            input logic [63:0] s1, input logic [63:0] s2,
                                            input logic [TAG_W-1:0] tag);
        logic [63:0] r;
        logic        lt;
        r  = '0;
        lt = 1'b0;
        case (op[1:0])
            2'b01, 2'b11: r = s1 + s2;
            2'b10:        r = s1 - s2;
            default:      r = '0;
        endcase
        if (op[2] && op[1:0] != 2'b00) r = {{32{r[31]}}, r[31:0]};
        if (op[1:0] == 2'b10) lt = uns ? (s1 < s2) : ($signed(s1) < $signed(s2));
        return {r, lt, tag};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [PW-1:0] got;
        logic [PW-1:0] want;
        if (rst_n && bus.out_vld && bus.out_rdy) begin
            got = {bus.out_rslt, bus.out_lt, bus.out_tag};
            checks++;
            rx_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, required no output", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL sb_result: got rslt=%h lt=%b tag=%0d, required rslt=%h lt=%b tag=%0d",
                             got[PW-1 -: XLEN], got[TAG_W], got[TAG_W-1:0],
                             want[PW-1 -: XLEN], want[TAG_W], want[TAG_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic uns, input logic [63:0] s1,
                        input logic [63:0] s2, input logic [TAG_W-1:0] tag, output int acc_cyc);
        bit acc;
        acc     = 1'b0;
        acc_cyc = -1;
        bus.in_vld      = 1'b1;
        bus.in_op       = op;
        bus.in_unsigned = uns;
        bus.in_s1       = s1;
        bus.in_s2       = s2;
        bus.in_tag      = tag;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                acc     = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(model(op, uns, s1, s2, tag));
            end
            @(posedge clk);
            #1;
        end
        bus.in_vld = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_rdy never high for tag %0d, required acceptance", tag);
        end
    endtask

    // Returns at the falling edge where out_vld is first seen high.
    task automatic wait_out(output bit seen, output int at_cyc);
        seen   = 1'b0;
        at_cyc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.out_vld) begin
                seen   = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld: got %b, required 0", bus.out_vld); end
        checks++; if (bus.out_rslt !== '0) begin errors++; $display("FAIL rst_out_rslt: got %h, required 0", bus.out_rslt); end
        checks++; if (bus.out_lt !== 1'b0) begin errors++; $display("FAIL rst_out_lt: got %b, required 0", bus.out_lt); end
        checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL rst_out_tag: got %0d, required 0", bus.out_tag); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b, required 1", bus.in_rdy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int acc, at;
        bit seen;
        send(3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd5, acc);
        wait_out(seen, at);
        checks++; if (!seen || at - acc != STAGES) begin errors++; $display("FAIL add_latency: got %0d, required %0d", at - acc, STAGES); end
        checks++; if (bus.out_rslt !== 64'd0) begin errors++; $display("FAIL add_rslt: got %h, required 0", bus.out_rslt); end
        checks++; if (bus.out_lt !== 1'b0) begin errors++; $display("FAIL add_lt: got %b, required 0", bus.out_lt); end
        checks++; if (bus.out_tag !== 6'd5) begin errors++; $display("FAIL add_tag: got %0d, required 5", bus.out_tag); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addw();
        int acc, at;
        bit seen;
        send(3'b101, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'd1, 6'd6, acc);
        wait_out(seen, at);
        checks++; if (!seen || bus.out_rslt !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL addw_rslt: got %h, required ffffffff80000000", bus.out_rslt); end
        @(posedge clk);
        #1;
        // Same stimulus on the 32-bit, single-stage unit.
        bus32.in_vld      = 1'b1;
        bus32.in_op       = 3'b101;
        bus32.in_unsigned = 1'b0;
        bus32.in_s1       = 32'h7FFF_FFFF;
        bus32.in_s2       = 32'd1;
        bus32.in_tag      = 6'd7;
        @(negedge clk);
        checks++; if (bus32.in_rdy !== 1'b1) begin errors++; $display("FAIL addw32_in_rdy: got %b, required 1", bus32.in_rdy); end
        @(posedge clk);
        #1;
        bus32.in_vld = 1'b0;
        @(negedge clk);
        checks++; if (bus32.out_vld !== 1'b1 || bus32.out_rslt !== 32'h8000_0000 || bus32.out_tag !== 6'd7) begin
            errors++; $display("FAIL addw32_rslt: got vld=%b rslt=%h tag=%0d, required vld=1 rslt=80000000 tag=7",
                               bus32.out_vld, bus32.out_rslt, bus32.out_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub_lt();
        logic [2:0]  ops  [3] = '{3'b010, 3'b010, 3'b110};
        logic        unss [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] s1v  [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        logic [63:0] exp_r[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
        logic        exp_l[3] = '{1'b1, 1'b0, 1'b1};
        int acc, at;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], unss[i], s1v[i], 64'd1, TAG_W'(30 + i), acc);
            wait_out(seen, at);
            checks++; if (!seen || bus.out_rslt !== exp_r[i]) begin errors++; $display("FAIL sub_rslt[%0d]: got %h, required %h", i, bus.out_rslt, exp_r[i]); end
            checks++; if (bus.out_lt !== exp_l[i]) begin errors++; $display("FAIL sub_lt[%0d]: got %b, required %b", i, bus.out_lt, exp_l[i]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int first_acc, last_acc, acc, rx0;
        rx0 = rx_count;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < 24; i++) begin
            send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rnd64(), rnd64(), TAG_W'(i), acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        checks++; if (last_acc - first_acc != 23) begin errors++; $display("FAIL b2b_throughput: got %0d cycles, required 23", last_acc - first_acc); end
        checks++; if (rx_count - rx0 != 24 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d results, required 24", rx_count - rx0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int rx0;
        rx0 = rx_count;
        fork
            begin
                int acc;
                for (int t = 0; t < 8; t++) begin
                    send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rnd64(), rnd64(), TAG_W'(t), acc);
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_rdy = !(c >= 3 && c <= 7);
                    @(negedge clk);
                    if (c == 7) begin
                        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_full: got %b, required 0", bus.in_rdy); end
                        checks++; if (bus.out_vld !== 1'b1 || bus.out_tag !== 6'd1) begin errors++; $display("FAIL bp_hold: got vld=%b tag=%0d, required vld=1 tag=1", bus.out_vld, bus.out_tag); end
                    end
                    if (c == 8) begin
                        checks++; if (bus.in_rdy !== 1'b1) begin errors++; $display("FAIL bp_in_rdy_recover: got %b, required 1", bus.in_rdy); end
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        checks++; if (rx_count - rx0 != 8 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d results, required 8", rx_count - rx0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        int acc, at, hi;
        bit seen;
        bus.out_rdy = 1'b0;
        send(3'b001, 1'b0, 64'd10, 64'd20, 6'd10, acc);
        send(3'b010, 1'b0, 64'd10, 64'd20, 6'd11, acc);
        flush           = 1'b1;
        bus.in_vld      = 1'b1;
        bus.in_op       = 3'b001;
        bus.in_s1       = 64'd1;
        bus.in_s2       = 64'd1;
        bus.in_tag      = 6'd13;
        @(negedge clk);
        checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_rdy: got %b, required 0", bus.in_rdy); end
        @(posedge clk);
        #1;
        flush      = 1'b0;
        bus.in_vld = 1'b0;
        exp_q.delete();
        bus.out_rdy = 1'b1;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.out_vld) hi++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL flush_out_vld: got %0d valid cycles, required 0", hi); end
        @(posedge clk);
        #1;
        send(3'b001, 1'b0, 64'd40, 64'd2, 6'd12, acc);
        wait_out(seen, at);
        checks++; if (!seen || at - acc != STAGES) begin errors++; $display("FAIL flush_latency: got %0d, required %0d", at - acc, STAGES); end
        checks++; if (bus.out_rslt !== 64'd42 || bus.out_tag !== 6'd12) begin errors++; $display("FAIL flush_next: got rslt=%h tag=%0d, required rslt=2a tag=12", bus.out_rslt, bus.out_tag); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int acc, at;
        bit seen;
        bus.out_rdy = 1'b0;
        send(3'b010, 1'b0, 64'd1, 64'd2, 6'd20, acc);
        send(3'b001, 1'b0, 64'd3, 64'd4, 6'd21, acc);
        #3;
        checks++; if (bus.out_vld !== 1'b1 || bus.out_tag !== 6'd20) begin errors++; $display("FAIL rmid_full: got vld=%b tag=%0d, required vld=1 tag=20", bus.out_vld, bus.out_tag); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL rmid_out_vld: got %b, required 0", bus.out_vld); end
        checks++; if (bus.out_rslt !== '0) begin errors++; $display("FAIL rmid_out_rslt: got %h, required 0", bus.out_rslt); end
        checks++; if (bus.out_lt !== 1'b0) begin errors++; $display("FAIL rmid_out_lt: got %b, required 0", bus.out_lt); end
        checks++; if (bus.out_tag !== '0) begin errors++; $display("FAIL rmid_out_tag: got %0d, required 0", bus.out_tag); end
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        @(posedge clk);
        #1;
        send(3'b001, 1'b0, 64'd100, 64'd23, 6'd22, acc);
        wait_out(seen, at);
        checks++; if (!seen || at - acc != STAGES) begin errors++; $display("FAIL rmid_latency: got %0d, required %0d", at - acc, STAGES); end
        checks++; if (bus.out_rslt !== 64'd123 || bus.out_tag !== 6'd22) begin errors++; $display("FAIL rmid_next: got rslt=%h tag=%0d, required rslt=7b tag=22", bus.out_rslt, bus.out_tag); end
        @(posedge clk);
        #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.in_vld        = 1'b0;
        bus.in_op         = '0;
        bus.in_unsigned   = 1'b0;
        bus.in_s1         = '0;
        bus.in_s2         = '0;
        bus.in_tag        = '0;
        bus.out_rdy       = 1'b1;
        bus32.in_vld      = 1'b0;
        bus32.in_op       = '0;
        bus32.in_unsigned = 1'b0;
        bus32.in_s1       = '0;
        bus32.in_s2       = '0;
        bus32.in_tag      = '0;
        bus32.out_rdy     = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_add();
        test_addw();
        test_sub_lt();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
